sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, block width fixed at 512 bits.
REQ-002 aclk  input  1  single clock; all logic rising-edge.
REQ-003 areset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input word valid.
REQ-005 in_ready  output  1  padder accepts word this cycle.
REQ-006 in_data  input  32  message word, big-endian: first byte in [31:24].
REQ-007 in_last  input  1  word is last of message.
REQ-008 in_bytes  input  2  valid bytes in last word, left-justified; 0 means 4; ignored unless in_last.
REQ-009 blk_valid  output  1  512-bit block valid, for the SHA-256 core downstream.
REQ-010 blk_ready  input  1  core accepts block.
REQ-011 blk_data  output  512  block; word i at [511-32i -: 32].
REQ-012 blk_last  output  1  block is final block of message (qualified by blk_valid).

Function
REQ-013 Transfer on in_valid&in_ready; block transfer on blk_valid&blk_ready.
REQ-014 States: FILL, PAD, EMIT, EXTRA; reset state FILL.
REQ-015 FILL: in_ready=1; each accepted word written to word index wcnt (0..15), wcnt increments; bit counter += 32, or 8*in_bytes for last word (in_bytes 0 counts 32).
REQ-016 FILL, word 15 accepted with in_last=0 -> EMIT, blk_last=0, wcnt=0.
REQ-017 FILL, in_last accepted -> PAD next cycle; bytes beyond in_bytes in that word are replaced: first byte 0x80, rest 0x00; if in_bytes=0 (full word) 0x80000000 goes in next word index.
REQ-018 PAD (exactly 1 cycle, in_ready=0): all words after the 0x80 word zeroed; if 0x80 word index <=13, words 14/15 = 64-bit bit length (word 14 high half), blk_last=1, -> EMIT; else -> EMIT with blk_last=0 and EXTRA pending.
REQ-019 0x80 word index 16 (full last word at index 15): current block emitted unpadded, EXTRA block starts with 0x80000000 in word 0.
REQ-020 EMIT: blk_valid=1, in_ready=0; blk_data and blk_last held stable until blk_ready; on handshake -> EXTRA if pending, else FILL.
REQ-021 EXTRA (1 cycle): block = 0x80 word (if REQ-019) else zeros, words 14/15 = length, blk_last=1 -> EMIT.
REQ-022 blk_valid asserts the cycle after the 16th word handshake (full block) or 1 cycle after PAD/EXTRA; no combinational path in_valid->blk_valid or blk_ready->in_ready.
REQ-023 Bit counter 64-bit, wraps mod 2^64; cleared after blk_last handshake; minimum message length 1 byte (zero-length unsupported).
REQ-024 Throughput: one word per cycle in FILL; one block per 17 cycles at full rate with blk_ready tied high.

Reset
REQ-025 areset sampled at aclk rise overrides all: state FILL, wcnt=0, bit counter=0, EXTRA pending=0, blk_valid=0, blk_last=0, in_ready=0 during reset cycle then 1, blk_data=0.
REQ-026 Reset mid-message or mid-EMIT discards partial data; no block emitted for it.

Verification
REQ-027 "abc": one word 0x61626300, in_last, in_bytes=3 -> one block: word0 0x61626380, words1-14 0, word15 0x00000018, blk_last=1.
REQ-028 55 bytes (13 full words + 3 bytes) -> one block, word13 ends 0x80, word15 0x000001B8, blk_last=1; 56 bytes -> two blocks, first blk_last=0 with word14=0x80000000, second zeros + word15 0x000001C0, blk_last=1.
REQ-029 64 bytes -> block1 = 16 input words blk_last=0; block2 word0 0x80000000, word15 0x00000200, blk_last=1.
REQ-030 blk_ready low for 10 cycles during EMIT -> blk_valid stays 1, blk_data unchanged, in_ready 0; release -> handshake, in_ready 1 next cycle.
REQ-031 areset asserted after 5 words of a message -> all outputs at reset values; subsequent "abc" yields exactly REQ-027 block (length 0x18, no stale words).

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian message words into 512-bit
// blocks and appends the 0x80 marker, zero fill and 64-bit bit length.
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   in_valid/in_ready      input word handshake (in_data, in_last, in_bytes)
//   blk_valid/blk_ready    output block handshake (blk_data, blk_last)
module sha256_msg_padder (
  input  logic         aclk,
  input  logic         areset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 512;
  localparam int unsigned NW = 16;
  localparam int unsigned LW = 64;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_EXTRA} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [LW-1:0]   bitcnt_q, bitcnt_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [4:0]      pad_idx_q, pad_idx_d;
  logic            full_q, full_d;
  logic            extra_pend_q, extra_pend_d;
  logic            extra_80_q, extra_80_d;
  logic            blk_last_q, blk_last_d;
  logic            in_ready_q, in_ready_d;
  logic            blk_valid_q, blk_valid_d;

  logic            in_fire;
  logic [2:0]      nb;
  logic [DW-1:0]   masked;
  logic [LW-1:0]   add_bits;

  // Last-word byte masking: keep nb bytes, then 0x80, then zeros.
  always_comb begin
    nb     = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    masked = in_data;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nb)       masked[DW-1-8*b -: 8] = in_data[DW-1-8*b -: 8];
      else if (3'(b) == nb) masked[DW-1-8*b -: 8] = 8'h80;
      else                  masked[DW-1-8*b -: 8] = 8'h00;
    end
    add_bits = in_last ? {58'd0, nb, 3'd0} : 64'd32;
  end

  assign in_fire = in_valid && in_ready_q && (state_q == S_FILL);

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    bitcnt_d     = bitcnt_q;
    blk_d        = blk_q;
    pad_idx_d    = pad_idx_q;
    full_d       = full_q;
    extra_pend_d = extra_pend_q;
    extra_80_d   = extra_80_q;
    blk_last_d   = blk_last_q;

    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          for (int i = 0; i < NW; i++) begin
            if (4'(i) == wcnt_q) blk_d[BW-1-DW*i -: DW] = in_last ? masked : in_data;
          end
          bitcnt_d = bitcnt_q + add_bits;
          if (in_last) begin
            // A full last word pushes the 0x80 marker into the next index (may be 16).
            pad_idx_d = (nb == 3'd4) ? 5'(wcnt_q) + 5'd1 : 5'(wcnt_q);
            full_d    = (nb == 3'd4);
            state_d   = S_PAD;
          end else if (wcnt_q == 4'd15) begin
            blk_last_d = 1'b0;
            wcnt_d     = 4'd0;
            state_d    = S_EMIT;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < NW; i++) begin
          if (5'(i) > pad_idx_q) blk_d[BW-1-DW*i -: DW] = '0;
          if (5'(i) == pad_idx_q && full_q) blk_d[BW-1-DW*i -: DW] = 32'h8000_0000;
        end
        if (pad_idx_q <= 5'd13) begin
          blk_d[2*DW-1:0] = bitcnt_q;
          blk_last_d      = 1'b1;
        end else begin
          blk_last_d   = 1'b0;
          extra_pend_d = 1'b1;
          extra_80_d   = (pad_idx_q == 5'd16);
        end
        wcnt_d  = 4'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (blk_ready) begin
          if (blk_last_q) bitcnt_d = '0;
          state_d = extra_pend_q ? S_EXTRA : S_FILL;
        end
      end
      S_EXTRA: begin
        blk_d = '0;
        if (extra_80_q) blk_d[BW-1 -: DW] = 32'h8000_0000;
        blk_d[2*DW-1:0] = bitcnt_q;
        blk_last_d      = 1'b1;
        extra_pend_d    = 1'b0;
        extra_80_d      = 1'b0;
        state_d         = S_EMIT;
      end
      default: state_d = S_FILL;
    endcase

    in_ready_d  = (state_d == S_FILL);
    blk_valid_d = (state_d == S_EMIT);
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_FILL;
      wcnt_q       <= '0;
      bitcnt_q     <= '0;
      blk_q        <= '0;
      pad_idx_q    <= '0;
      full_q       <= 1'b0;
      extra_pend_q <= 1'b0;
      extra_80_q   <= 1'b0;
      blk_last_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      blk_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      bitcnt_q     <= bitcnt_d;
      blk_q        <= blk_d;
      pad_idx_q    <= pad_idx_d;
      full_q       <= full_d;
      extra_pend_q <= extra_pend_d;
      extra_80_q   <= extra_80_d;
      blk_last_q   <= blk_last_d;
      in_ready_q   <= in_ready_d;
      blk_valid_q  <= blk_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_q;
  assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: expected blocks come from standard SHA-256
// byte-level padding of each message (bytes, 0x80, zeros to 56 mod 64, length).
module tb_sha256_msg_padder;

  logic         aclk = 1'b0;
  logic         areset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  int vec_cnt = 0;
  int miscmp  = 0;
  byte unsigned msg_q[$];
  logic [511:0] last_blk;
  logic [511:0] abc_blk;
  int nblk;

  sha256_msg_padder dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Sends msg_q with random valid/ready gaps and checks every block delivered.
  task automatic run_msg(input int rdy_pct, input int vld_pct, output int nb_out);
    logic [511:0] exp_b[$];
    logic         exp_l[$];
    byte unsigned p[$];
    logic [511:0] blk;
    logic [63:0]  bl;
    int nbytes, nwords, wi, cyc, nblocks;
    nbytes = msg_q.size();
    nwords = (nbytes + 3) / 4;
    wi = 0;
    cyc = 0;
    nb_out = 0;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(nbytes) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblocks = p.size() / 64;
    for (int b = 0; b < nblocks; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_b.push_back(blk);
      exp_l.push_back(b == nblocks - 1);
    end
    while ((wi < nwords || exp_b.size() > 0) && cyc < 4000) begin
      tick();
      cyc++;
      in_valid = (wi < nwords) && ($urandom_range(99) < 32'(vld_pct));
      in_data  = $urandom;
      for (int k = 0; k < 4; k++)
        if (4*wi + k < nbytes) in_data[31-8*k -: 8] = msg_q[4*wi+k];
      in_last  = (wi == nwords - 1);
      in_bytes = in_last ? 2'(nbytes % 4) : 2'($urandom);
      blk_ready = ($urandom_range(99) < 32'(rdy_pct));
      if (in_valid && in_ready) wi++;
      if (blk_valid && blk_ready) begin
        nb_out++;
        last_blk = blk_data;
        if (exp_b.size() == 0) chk("extra_blk", 512'(blk_valid), 512'(0));
        else begin
          chk("blk_data", blk_data, exp_b.pop_front());
          chk("blk_last", 512'(blk_last), 512'(exp_l.pop_front()));
        end
      end
    end
    chk("timeout", 512'(cyc < 4000), 512'(1));
    tick();
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    chk("idle_valid", 512'(blk_valid), 512'(0));
  endtask

  initial begin
    abc_blk   = {32'h6162_6380, 448'h0, 32'h0000_0018};
    areset    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_last", 512'(blk_last), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    areset = 1'b0;
    tick();
    chk("post_rst_ready", 512'(in_ready), 512'(1));

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(100, 100, nblk);
    chk("abc_literal", last_blk, abc_blk);
    chk("abc_nblk", 512'(nblk), 512'(1));

    // Length boundaries
    rand_msg(55); run_msg(100, 100, nblk); chk("len55_nblk", 512'(nblk), 512'(1));
    rand_msg(56); run_msg(100, 100, nblk); chk("len56_nblk", 512'(nblk), 512'(2));
    rand_msg(64); run_msg(100, 100, nblk); chk("len64_nblk", 512'(nblk), 512'(2));
    chk("len64_blk2", last_blk, {32'h8000_0000, 448'h0, 32'h0000_0200});
    rand_msg(60); run_msg(100, 100, nblk); chk("len60_nblk", 512'(nblk), 512'(2));

    // Downstream stall holds the block
    in_valid = 1'b1; in_data = 32'h6162_63A5; in_last = 1'b1; in_bytes = 2'd3;
    blk_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 10 && !blk_valid; w++) tick();
    chk("stall_valid_up", 512'(blk_valid), 512'(1));
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", 512'(blk_valid), 512'(1));
      chk("stall_data", blk_data, abc_blk);
      chk("stall_ready", 512'(in_ready), 512'(0));
    end
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    chk("stall_rel_ready", 512'(in_ready), 512'(1));
    chk("stall_rel_valid", 512'(blk_valid), 512'(0));

    // Reset after 5 words discards partial message
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    areset = 1'b1;
    tick();
    chk("mid_rst_ready", 512'(in_ready), 512'(0));
    chk("mid_rst_valid", 512'(blk_valid), 512'(0));
    chk("mid_rst_last", 512'(blk_last), 512'(0));
    chk("mid_rst_data", blk_data, 512'(0));
    areset = 1'b0;
    tick();
    chk("mid_rst_ready1", 512'(in_ready), 512'(1));
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(70, 80, nblk);
    chk("abc_after_rst", last_blk, abc_blk);

    // Randomized messages with random gaps
    for (int m = 0; m < 30; m++) begin
      rand_msg(int'($urandom_range(1, 150)));
      run_msg(int'($urandom_range(30, 100)), int'($urandom_range(50, 100)), nblk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
